// File: rtl/hamming74_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : hamming74_pkg                                                |
// | Description : Hamming(7,4) widths, decode result type and the encode /     |
// |               decode functions shared by the transmitter and receiver.     |
// |               Codeword bit i holds Hamming position i+1:                   |
// |               {d3,d2,d1,p4,d0,p2,p1}.                                      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package hamming74_pkg;

    localparam int CW_W   = 7;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              corrected;
    } dec_t;

    function automatic logic [CW_W-1:0] hamming74_encode(input logic [DATA_W-1:0] d);
        logic p1;
        logic p2;
        logic p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    // A nonzero syndrome names the 1-based position to flip. Double-bit
    // errors produce a nonzero syndrome too and are "corrected" wrongly.
    function automatic dec_t hamming74_decode(input logic [CW_W-1:0] cw);
        logic [SYN_W-1:0] syn;
        logic [CW_W-1:0]  fixed;
        dec_t             res;
        syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        fixed  = cw;
        if (syn != '0) begin
            fixed[syn - 1'b1] = ~cw[syn - 1'b1];
        end
        res.data      = {fixed[6], fixed[5], fixed[4], fixed[2]};
        res.corrected = (syn != '0);
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hamming74_receiver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : hamming74_receiver_if                                        |
// | Description : Codeword input link, decoded-nibble valid/ready output and   |
// |               error-counter monitor signals of the Hamming(7,4) receiver.  |
// |   rx/rx_valid/busy        : codeword link (busy = no credit left)          |
// |   data_out/corrected/out_valid/out_ready : decoded output handshake        |
// |   clr_count/err_count     : corrected-word counter clear and value         |
// |   master = link driver and consumer, slave = receiver                      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface hamming74_receiver_if #(
    parameter int CNT_W = 8
);
    import hamming74_pkg::*;

    logic [CW_W-1:0]   rx;
    logic              rx_valid;
    logic              busy;
    logic [DATA_W-1:0] data_out;
    logic              corrected;
    logic              out_valid;
    logic              out_ready;
    logic              clr_count;
    logic [CNT_W-1:0]  err_count;

    modport master (
        output rx, rx_valid, out_ready, clr_count,
        input  busy, data_out, corrected, out_valid, err_count
    );

    modport slave (
        input  rx, rx_valid, out_ready, clr_count,
        output busy, data_out, corrected, out_valid, err_count
    );

endinterface
`default_nettype wire

// File: rtl/hamming74_receiver_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hamming74_receiver_sync_fifo                                 |
// | Description : Single-clock FIFO, DEPTH a power of two.                     |
// |   clk, rst_n : clock, asynchronous active-low reset                        |
// |   push/wdata : write; accepted when not full or when popping too           |
// |   pop        : read; ignored while empty                                   |
// |   rdata      : head entry, forced to 0 while empty                         |
// |   count      : number of stored entries                                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module hamming74_receiver_sync_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign w_pop  = pop && (count_q != '0);
    // Writing into a full FIFO is legal when the head leaves in the same cycle.
    assign w_push = push && ((count_q != (AW+1)'(DEPTH)) || w_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(w_push);
        rd_ptr_d = rd_ptr_q + AW'(w_pop);
        count_d  = count_q + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/hamming74_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hamming74_receiver                                           |
// | Description : Hamming(7,4) receiver: capture stage, decode/correct stage,  |
// |               output FIFO with credit-based busy, saturating counter of    |
// |               corrected words.                                             |
// |   clk, rst_n : clock, asynchronous active-low reset                        |
// |   bus        : hamming74_receiver_if.slave (link, output, counter)         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module hamming74_receiver
    import hamming74_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hamming74_receiver_if.slave   bus
);
    localparam int FC_W = $clog2(DEPTH) + 1;

    logic              s1_v_q,    s1_v_d;
    logic [CW_W-1:0]   s1_cw_q,   s1_cw_d;
    logic              s2_v_q,    s2_v_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    logic              s2_corr_q, s2_corr_d;
    logic              busy_q,    busy_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;

    dec_t              w_dec;
    logic              w_accept;
    logic              w_pop;
    logic              w_out_valid;
    logic [DATA_W:0]   w_head;
    logic [FC_W-1:0]   w_fifo_count;
    logic [FC_W-1:0]   w_fifo_count_nxt;
    logic [FC_W:0]     w_credit_used_nxt;

    assign w_accept    = bus.rx_valid && !busy_q;
    assign w_out_valid = (w_fifo_count != '0);
    assign w_pop       = w_out_valid && bus.out_ready;
    assign w_dec       = hamming74_decode(s1_cw_q);

    always_comb begin
        s1_v_d    = w_accept;
        s1_cw_d   = w_accept ? bus.rx : s1_cw_q;
        s2_v_d    = s1_v_q;
        s2_data_d = s1_v_q ? w_dec.data : s2_data_q;
        s2_corr_d = s1_v_q ? w_dec.corrected : s2_corr_q;

        // busy is the registered image of "credits in use >= DEPTH" evaluated
        // on the state that will exist after this edge, so out_ready only
        // reaches busy through a flop and the window can never overfill.
        w_fifo_count_nxt  = w_fifo_count + FC_W'(s2_v_q) - FC_W'(w_pop);
        w_credit_used_nxt = {1'b0, w_fifo_count_nxt} + (FC_W+1)'(s1_v_d)
                          + (FC_W+1)'(s2_v_d);
        busy_d            = (w_credit_used_nxt >= (FC_W+1)'(DEPTH));

        // Clear takes priority; a coincident increment is dropped.
        err_count_d = err_count_q;
        if (bus.clr_count) begin
            err_count_d = '0;
        end else if (s2_v_q && s2_corr_q && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q      <= 1'b0;
            s1_cw_q     <= '0;
            s2_v_q      <= 1'b0;
            s2_data_q   <= '0;
            s2_corr_q   <= 1'b0;
            busy_q      <= 1'b0;
            err_count_q <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_cw_q     <= s1_cw_d;
            s2_v_q      <= s2_v_d;
            s2_data_q   <= s2_data_d;
            s2_corr_q   <= s2_corr_d;
            busy_q      <= busy_d;
            err_count_q <= err_count_d;
        end
    end

    hamming74_receiver_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s2_v_q),
        .wdata ({s2_data_q, s2_corr_q}),
        .pop   (w_pop),
        .rdata (w_head),
        .count (w_fifo_count)
    );

    assign bus.busy      = busy_q;
    assign bus.out_valid = w_out_valid;
    assign bus.data_out  = w_head[DATA_W:1];
    assign bus.corrected = w_head[0];
    assign bus.err_count = err_count_q;

endmodule
`default_nettype wire
